// File: rtl/data_mem_pipe_pkg.sv
// Shared types and default parameters for the data_mem_pipe memory block.
package data_mem_pipe_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 4096;
  localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/data_mem_pipe_rsp_pipe.sv
// Fixed-latency response delay line: valid, read data and error travel together.
module mem_rsp_pipe #(
  parameter int RD_LAT = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] rdata_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) rdata_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_err;
      rdata_q[0] <= in_rdata;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];
  assign out_rdata = rdata_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_pipe.sv
// Single-port word memory with byte enables, self-clearing INIT sequence and
// fixed-latency, non-backpressured responses.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy,
  output state_t              dbg_state
);

  localparam int NB = DATA_W / 8;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [CW-1:0]     clr_cnt;
  logic              accept;
  logic              in_range;
  logic [MW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;

  // A request transfers on a rising edge where req_valid && req_ready; the
  // response follows RD_LAT cycles later and can never be stalled.
  assign req_ready = (state == ST_RUN) && !clr;
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
  assign idx       = req_addr[MW-1:0];
  assign rd_word   = mem[idx];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == CW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            clr_cnt   <= '0;
            init_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; zeros come only from the INIT sweep.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_cnt[MW-1:0]] <= '0;
    end else if (accept && req_wr && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  mem_rsp_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_rdata  ((accept && !req_wr && in_range) ? rd_word : '0),
    .in_err    (accept && !in_range),
    .out_valid (rsp_valid),
    .out_rdata (rsp_rdata),
    .out_err   (rsp_err)
  );

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 12, request address width.
REQ-003 Parameter DEPTH, default 4096, implemented words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, response latency in cycles; legal range 1..3.
REQ-005 Port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-007 Port clr, input, 1, synchronous pulse requesting a full memory clear.
REQ-008 Port req_valid, input, 1, request present.
REQ-009 Port req_ready, output, 1, request accepted when high with req_valid.
REQ-010 Port req_wr, input, 1: 1 = write, 0 = read.
REQ-011 Port req_addr, input, ADDR_W, word address.
REQ-012 Port req_wdata, input, DATA_W, write data.
REQ-013 Port req_be, input, DATA_W/8, byte-lane write enables; bit i covers bits 8i+7..8i.
REQ-014 Port rsp_valid, output, 1, one-cycle response strobe.
REQ-015 Port rsp_rdata, output, DATA_W, read data; 0 for writes and errors.
REQ-016 Port rsp_err, output, 1, address out of range (req_addr >= DEPTH); qualified by rsp_valid.
REQ-017 Port init_busy, output, 1, high while clear sequence runs.

Function
REQ-018 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-019 INIT SHALL write 0 to one word per cycle, addresses 0 to DEPTH-1 ascending, then go to RUN; duration exactly DEPTH cycles.
REQ-020 req_ready SHALL be high iff state is RUN and clr is low (combinational).
REQ-021 clr high in RUN SHALL enter INIT next cycle with clear counter at 0; clr in INIT SHALL be ignored (no restart).
REQ-022 clr and req_valid in the same cycle: clr wins, request not accepted, no response generated.
REQ-023 Accepted write with in-range address SHALL update only lanes whose req_be bit is 1, at the accept edge.
REQ-024 Accepted read SHALL return the memory word as of the accept edge, including a write accepted in the previous cycle.
REQ-025 Every accepted request SHALL produce exactly one rsp_valid pulse exactly RD_LAT cycles after the accept edge, in order; no response backpressure.
REQ-026 Out-of-range access: no memory change, rsp_rdata = 0, rsp_err = 1.
REQ-027 Write response: rsp_rdata = 0, rsp_err set only per REQ-026.
REQ-028 Write with req_be all 0 SHALL change no memory but still respond.
REQ-029 Back-to-back accepts every cycle SHALL be sustained (throughput 1/cycle).
REQ-030 Responses in flight when clr takes effect SHALL still be delivered at their scheduled cycle.
REQ-031 Address width arithmetic: clear counter SHALL be wide enough to hold DEPTH without wrap before termination.

Reset
REQ-032 rst_n low SHALL asynchronously force: state INIT, clear counter 0, init_busy 1, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, pipeline stages invalid.
REQ-033 Reset mid-operation SHALL discard all in-flight responses; memory SHALL be fully re-cleared by INIT after release.
REQ-034 Memory array itself SHALL not be reset; zero contents come solely from INIT.

Structure
REQ-035 Shared package SHALL hold the FSM state enumeration and default parameter constants (DATA_W, ADDR_W, DEPTH, RD_LAT).
REQ-036 Response latency SHALL be one sub-module, mem_rsp_pipe, parametrised by RD_LAT and DATA_W, carrying valid, rdata, err.
REQ-037 No initial-block memory preload SHALL be used.

Verification
REQ-038 Reset release, DEPTH=16 -> init_busy high exactly 16 cycles, req_ready low throughout, then high; reads of all 16 addresses return 0x0000.
REQ-039 Write 0xABCD to addr 3, be=11, next cycle read addr 3, RD_LAT=2 -> rsp_valid 2 cycles after each accept; read returns 0xABCD.
REQ-040 Addr 3 = 0xABCD, write 0x1200 with be=10 -> read returns 0x12CD.
REQ-041 DEPTH=16, read addr 20 -> rsp_err 1, rsp_rdata 0; write addr 20 leaves all 16 words unchanged.
REQ-042 Stream 8 reads with req_valid held high, clr pulsed at 4th -> 3 responses delivered, 4th not accepted, init_busy high 16 cycles, memory all zero afterward.
REQ-043 rst_n asserted with 2 responses in flight -> rsp_valid 0 immediately and no late pulse after release.
